// File: rtl/sphere_hit_pipeline.sv
// sphere_hit_pipeline: ray/sphere hit test over a sphere table, 5-stage arithmetic pipeline.
// Define SPHERE_TANGENT_HIT_EN to count tangent rays (disc==0) as hits.
module sphere_hit_pipeline #(
  parameter int COORD_W = 12,
  parameter int RAD_W = 10,
  parameter int NUM_SPHERES = 4,
  localparam int AW = NUM_SPHERES > 1 ? $clog2(NUM_SPHERES) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [COORD_W-1:0] px,
  input  logic signed [COORD_W-1:0] py,
  input  logic signed [COORD_W-1:0] pz,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic                      sph_we,
  input  logic [AW-1:0]             sph_waddr,
  input  logic signed [COORD_W-1:0] sph_ox,
  input  logic signed [COORD_W-1:0] sph_oy,
  input  logic signed [COORD_W-1:0] sph_oz,
  input  logic [RAD_W-1:0]          sph_r,
  output logic                      hit_valid,
  input  logic                      hit_ready,
  output logic [NUM_SPHERES-1:0]    hit_mask,
  output logic                      any_hit,
  output logic [AW-1:0]             first_hit_idx
);
  localparam int P = 2 * COORD_W;
  localparam int RW2 = 2 * RAD_W;
  localparam int SW = (P > RW2 ? P : RW2) + 3;
  localparam int D = 2 * SW + 4;
  localparam logic [AW-1:0] LAST = AW'(NUM_SPHERES - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic signed [COORD_W-1:0] lx, ly, lz;
  logic signed [COORD_W-1:0] tx [NUM_SPHERES];
  logic signed [COORD_W-1:0] ty [NUM_SPHERES];
  logic signed [COORD_W-1:0] tz [NUM_SPHERES];
  logic [RAD_W-1:0] tr [NUM_SPHERES];
  logic [AW-1:0] idx, i1, i2, i3, i4, first;
  logic v1, v2, v3, v4, v5_last, hit;
  logic [NUM_SPHERES-1:0] wmask;
  logic signed [P-1:0] pxx, pyy, pzz, pxo, pyo, pzo, oxx, oyy, ozz;
  logic [RW2-1:0] rr;
  logic signed [SW-1:0] a, b, c;
  logic signed [D-1:0] ac, bb, disc;
  // Widths are sized so no intermediate can overflow at any parameter value.
  always_ff @(posedge clk) begin
    pxx <= P'(lx) * P'(lx);
    pyy <= P'(ly) * P'(ly);
    pzz <= P'(lz) * P'(lz);
    pxo <= P'(lx) * P'(tx[idx]);
    pyo <= P'(ly) * P'(ty[idx]);
    pzo <= P'(lz) * P'(tz[idx]);
    oxx <= P'(tx[idx]) * P'(tx[idx]);
    oyy <= P'(ty[idx]) * P'(ty[idx]);
    ozz <= P'(tz[idx]) * P'(tz[idx]);
    rr <= RW2'(tr[idx]) * RW2'(tr[idx]);
    a <= SW'(pxx) + SW'(pyy) + SW'(pzz);
    b <= (SW'(pxo) + SW'(pyo) + SW'(pzo)) <<< 1;
    c <= SW'(oxx) + SW'(oyy) + SW'(ozz) - SW'($signed({1'b0, rr}));
    ac <= D'(a) * D'(c);
    bb <= D'(b) * D'(b);
    disc <= bb - (ac <<< 2);
  end
`ifdef SPHERE_TANGENT_HIT_EN
  assign hit = !disc[D-1];
`else
  assign hit = !disc[D-1] && |disc;
`endif
  always_comb begin
    first = '0;
    for (int k = NUM_SPHERES - 1; k >= 0; k--) if (wmask[k]) first = AW'(k);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pix_ready <= 1'b0;
      hit_valid <= 1'b0;
      hit_mask <= '0;
      any_hit <= 1'b0;
      first_hit_idx <= '0;
      {v1, v2, v3, v4, v5_last} <= '0;
      {idx, i1, i2, i3, i4} <= '0;
      wmask <= '0;
      {lx, ly, lz} <= '0;
      for (int k = 0; k < NUM_SPHERES; k++) begin
        tx[k] <= '0;
        ty[k] <= '0;
        tz[k] <= '0;
        tr[k] <= '0;
      end
    end else begin
      v1 <= state == ISSUE;
      i1 <= idx;
      {v2, i2} <= {v1, i1};
      {v3, i3} <= {v2, i2};
      {v4, i4} <= {v3, i3};
      v5_last <= v4 && i4 == LAST;
      if (v4) wmask[i4] <= hit;
      if (sph_we && state == IDLE) begin
        tx[sph_waddr] <= sph_ox;
        ty[sph_waddr] <= sph_oy;
        tz[sph_waddr] <= sph_oz;
        tr[sph_waddr] <= sph_r;
      end
      case (state)
        IDLE: begin
          pix_ready <= !(pix_valid && pix_ready);
          if (pix_valid && pix_ready) begin
            {lx, ly, lz} <= {px, py, pz};
            wmask <= '0;
            idx <= '0;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          idx <= idx + 1'b1;
          if (idx == LAST) state <= DRAIN;
        end
        DRAIN: if (v5_last) begin
          state <= DONE;
          hit_valid <= 1'b1;
          hit_mask <= wmask;
          any_hit <= |wmask;
          first_hit_idx <= first;
        end
        DONE: if (hit_ready) begin
          state <= IDLE;
          hit_valid <= 1'b0;
          pix_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sphere_hit_pipeline.sv
// tb_sphere_hit_pipeline: random and directed checks against a plain-arithmetic sphere model.
module tb_sphere_hit_pipeline;
  localparam int N = 4;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic signed [11:0] px = '0, py = '0, pz = '0, sph_ox = '0, sph_oy = '0, sph_oz = '0;
  logic [9:0] sph_r = '0;
  logic pix_valid = 0, pix_ready, sph_we = 0, hit_valid, hit_ready = 1, any_hit;
  logic [1:0] sph_waddr = '0, first_hit_idx;
  logic [3:0] hit_mask;
  int passed = 0, total = 0;
  int mx [N], my [N], mz [N], mr [N];
  logic [3:0] exp_mask = '0, held_mask;
  logic exp_any = 0;
  logic [1:0] exp_first = '0;

  sphere_hit_pipeline dut (
    .clk(clk), .rst_n(rst_n), .px(px), .py(py), .pz(pz),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .sph_we(sph_we), .sph_waddr(sph_waddr), .sph_ox(sph_ox), .sph_oy(sph_oy),
    .sph_oz(sph_oz), .sph_r(sph_r), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_mask(hit_mask), .any_hit(any_hit), .first_hit_idx(first_hit_idx)
  );

  function automatic longint disc_of(int x, int y, int z, int ox, int oy, int oz, int r);
    longint a, b, c;
    a = longint'(x) * x + longint'(y) * y + longint'(z) * z;
    b = 2 * (longint'(x) * ox + longint'(y) * oy + longint'(z) * oz);
    c = longint'(ox) * ox + longint'(oy) * oy + longint'(oz) * oz - longint'(r) * r;
    return b * b - 4 * a * c;
  endfunction

  function automatic bit hit_of(longint d);
`ifdef SPHERE_TANGENT_HIT_EN
    return d >= 0;
`else
    return d > 0;
`endif
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  task automatic model_pixel(input int x, input int y, input int z);
    exp_mask = '0;
    for (int k = 0; k < N; k++) exp_mask[k] = hit_of(disc_of(x, y, z, mx[k], my[k], mz[k], mr[k]));
    exp_any = |exp_mask;
    exp_first = '0;
    for (int k = N - 1; k >= 0; k--) if (exp_mask[k]) exp_first = 2'(k);
  endtask

  task automatic wr(input int k, input int x, input int y, input int z, input int r);
    @(negedge clk);
    sph_we = 1;
    sph_waddr = 2'(k);
    sph_ox = 12'(x);
    sph_oy = 12'(y);
    sph_oz = 12'(z);
    sph_r = 10'(r);
    @(posedge clk);
    #1 sph_we = 0;
    mx[k] = x; my[k] = y; mz[k] = z; mr[k] = r;
  endtask

  task automatic run_pix(input int x, input int y, input int z);
    int n;
    bit ok;
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (pix_ready) begin ok = 1; break; end
    end
    chk("pix_ready_wait", ok, 1);
    px = 12'(x); py = 12'(y); pz = 12'(z);
    pix_valid = 1;
    model_pixel(x, y, z);
    @(posedge clk);
    #1 pix_valid = 0;
    n = 1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hit_valid) begin ok = 1; break; end
      @(posedge clk);
      n++;
    end
    chk("latency", ok ? n : -1, N + 6);
  endtask

  // Every cycle a result is presented, it must match the model's prediction.
  always @(negedge clk) if (rst_n && hit_valid) begin
    chk("hit_mask", hit_mask, exp_mask);
    chk("any_hit", any_hit, exp_any);
    chk("first_hit_idx", first_hit_idx, exp_first);
    chk("pix_ready_in_done", pix_ready, 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int x, y, z;
    for (int k = 0; k < N; k++) begin mx[k] = 0; my[k] = 0; mz[k] = 0; mr[k] = 0; end
    chk("model_disc16", disc_of(0, 0, 1, 0, 0, 10, 2), 16);
    chk("model_disc0", disc_of(0, 0, 1, 2, 0, 10, 2), 0);
    #2;
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_hit_valid", hit_valid, 0);
    chk("rst_outs", {hit_mask, any_hit, first_hit_idx}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1 chk("pix_ready_after_rst", pix_ready, 1);

    wr(0, 0, 0, 10, 2);
    for (int k = 1; k < N; k++) wr(k, 10, 0, 10, 0);
    run_pix(0, 0, 1);
    chk("t028_mask", hit_mask, 4'b0001);
    chk("t028_any", any_hit, 1);
    chk("t028_first", first_hit_idx, 0);

    wr(0, 10, 0, 10, 0);
    wr(2, 2, 0, 10, 2);
    run_pix(0, 0, 1);
`ifdef SPHERE_TANGENT_HIT_EN
    chk("t029_mask", hit_mask, 4'b0100);
`else
    chk("t029_mask", hit_mask, 4'b0000);
`endif

    for (int k = 0; k < N; k++) wr(k, -2048, -2048, -2048, 1023);
    run_pix(-2048, -2048, -2048);
    chk("t030_mask", hit_mask, 4'b1111);

    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0)
        for (int k = 0; k < N; k++)
          wr(k, int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048,
             int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 1023)));
      x = int'($urandom_range(0, 4095)) - 2048;
      y = int'($urandom_range(0, 4095)) - 2048;
      z = int'($urandom_range(0, 4095)) - 2048;
      run_pix(x, y, z);
    end

    for (int k = 0; k < N; k++) wr(k, -2048, -2048, -2048, 1023);
    hit_ready = 0;
    run_pix(-2048, -2048, -2048);
    held_mask = hit_mask;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", hit_valid, 1);
      chk("hold_mask", hit_mask, held_mask);
      if (i == 10) begin
        sph_we = 1; sph_waddr = 0; sph_ox = 12'sd10; sph_oy = 0; sph_oz = 12'sd10; sph_r = 0;
        pix_valid = 1;
      end
      if (i == 11) begin sph_we = 0; pix_valid = 0; end
    end
    hit_ready = 1;
    @(posedge clk);
    #1 chk("hold_released", hit_valid, 0);
    run_pix(-2048, -2048, -2048);
    chk("t031_write_dropped", hit_mask, 4'b1111);

    wr(1, 0, 0, 10, 2);
    @(negedge clk);
    px = 0; py = 0; pz = 12'sd1; pix_valid = 1;
    @(posedge clk);
    #1 pix_valid = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("t032_outs", {hit_valid, pix_ready, hit_mask, any_hit, first_hit_idx}, 0);
    @(negedge clk) rst_n = 1;
    for (int k = 0; k < N; k++) begin mx[k] = 0; my[k] = 0; mz[k] = 0; mr[k] = 0; end
    run_pix(0, 0, 1);
`ifdef SPHERE_TANGENT_HIT_EN
    chk("t032_mask", hit_mask, 4'b1111);
`else
    chk("t032_mask", hit_mask, 4'b0000);
`endif
    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
